// File: rtl/decode_stage.sv
// Registered decode stage: two-entry skid buffer in front of a combinational
// field split, so in_ready depends only on registered state.
module decode_stage #(
   parameter logic [31:0] SIGNED_OPS = 32'h0208_0000,
   parameter logic [31:0] LEGAL_OPS  = 32'h1FFF_FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [63:0] in_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_opcode,
   output logic [4:0]  out_rd,
   output logic [4:0]  out_rs,
   output logic [4:0]  out_rt,
   output logic [11:0] out_imm,
   output logic        out_imm_signed,
   output logic        out_illegal,
   output logic [63:0] out_pc
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t      state;
   logic [31:0] main_instr;
   logic [63:0] main_pc;
   logic [31:0] skid_instr;
   logic [63:0] skid_pc;
   logic        accept;
   logic        consume;

   assign in_ready  = (state != TWO);
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid & in_ready;
   assign consume   = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= EMPTY;
         main_instr <= '0;
         main_pc    <= '0;
         skid_instr <= '0;
         skid_pc    <= '0;
      end else if (flush) begin
         // Buffer contents are left as-is; state alone marks them dead.
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_instr <= in_instr;
                  main_pc    <= in_pc;
                  state      <= ONE;
               end
            end
            ONE: begin
               if (accept && consume) begin
                  main_instr <= in_instr;
                  main_pc    <= in_pc;
               end else if (accept) begin
                  skid_instr <= in_instr;
                  skid_pc    <= in_pc;
                  state      <= TWO;
               end else if (consume) begin
                  state <= EMPTY;
               end
            end
            TWO: begin
               if (consume) begin
                  main_instr <= skid_instr;
                  main_pc    <= skid_pc;
                  state      <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   assign out_opcode     = main_instr[31:27];
   assign out_rd         = main_instr[26:22];
   assign out_rs         = main_instr[21:17];
   assign out_rt         = main_instr[16:12];
   assign out_imm        = main_instr[11:0];
   assign out_imm_signed = SIGNED_OPS[out_opcode];
   assign out_illegal    = ~LEGAL_OPS[out_opcode];
   assign out_pc         = main_pc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, decode fields, streaming,
// back-pressure through the skid buffer, flush and asynchronous reset.
module tb_decode_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_opcode;
   logic [4:0]  out_rd;
   logic [4:0]  out_rs;
   logic [4:0]  out_rt;
   logic [11:0] out_imm;
   logic        out_imm_signed;
   logic        out_illegal;
   logic [63:0] out_pc;

   int checks = 0;
   int errors = 0;

   decode_stage #(
      .SIGNED_OPS(32'h0208_0000),
      .LEGAL_OPS (32'h1FFF_FFFF)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_instr      (in_instr),
      .in_pc         (in_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_opcode    (out_opcode),
      .out_rd        (out_rd),
      .out_rs        (out_rs),
      .out_rt        (out_rt),
      .out_imm       (out_imm),
      .out_imm_signed(out_imm_signed),
      .out_illegal   (out_illegal),
      .out_pc        (out_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [11:0] imm);
      return {op, rd, rs, rt, imm};
   endfunction

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      out_ready = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_opcode", 64'(out_opcode), 64'd0);
      check("rst_pc", out_pc, 64'd0);
      check("rst_illegal", 64'(out_illegal), 64'd0);
      check("rst_imm_signed", 64'(out_imm_signed), 64'd0);
      rst_n = 1'b1;
      tick();

      // Single word decode
      in_valid  = 1'b1;
      in_instr  = 32'hC8C8_0FFF;
      in_pc     = 64'h100;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t1_valid", 64'(out_valid), 64'd1);
      check("t1_opcode", 64'(out_opcode), 64'h19);
      check("t1_rd", 64'(out_rd), 64'd3);
      check("t1_rs", 64'(out_rs), 64'd4);
      check("t1_rt", 64'(out_rt), 64'd0);
      check("t1_imm", 64'(out_imm), 64'hFFF);
      check("t1_signed", 64'(out_imm_signed), 64'd1);
      check("t1_illegal", 64'(out_illegal), 64'd0);
      check("t1_pc", out_pc, 64'h100);
      tick();
      check("t1_drain", 64'(out_valid), 64'd0);

      // Back-to-back stream of 8 words, one output per cycle in order
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_instr = mk(5'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3), 12'(i * 16 + 1));
         in_pc    = 64'h1000 + 64'(4 * i);
         tick();
         check("s_valid", 64'(out_valid), 64'd1);
         check("s_ready", 64'(in_ready), 64'd1);
         check("s_pc", out_pc, 64'h1000 + 64'(4 * i));
         check("s_opcode", 64'(out_opcode), 64'(i));
         check("s_rt", 64'(out_rt), 64'(i + 3));
         check("s_imm", 64'(out_imm), 64'(i * 16 + 1));
      end
      in_valid = 1'b0;
      tick();
      check("s_drain", 64'(out_valid), 64'd0);

      // Back-pressure: out_ready low for 3 cycles
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = mk(5'd1, 5'd1, 5'd0, 5'd0, 12'h0A0);
      in_pc     = 64'h2000;
      tick();
      check("bp_w0_pc", out_pc, 64'h2000);
      check("bp_ready1", 64'(in_ready), 64'd1);
      in_instr = mk(5'd2, 5'd2, 5'd0, 5'd0, 12'h0A1);
      in_pc    = 64'h2004;
      tick();
      check("bp_ready_fall", 64'(in_ready), 64'd0);
      check("bp_hold_pc", out_pc, 64'h2000);
      in_instr = mk(5'd3, 5'd3, 5'd0, 5'd0, 12'h0A2);
      in_pc    = 64'h2008;
      tick();
      check("bp_ready_low", 64'(in_ready), 64'd0);
      check("bp_hold_pc2", out_pc, 64'h2000);
      check("bp_hold_imm", 64'(out_imm), 64'h0A0);
      out_ready = 1'b1;
      tick();
      check("bp_w1_pc", out_pc, 64'h2004);
      check("bp_ready_rise", 64'(in_ready), 64'd1);
      tick();
      check("bp_w2_pc", out_pc, 64'h2008);
      check("bp_w2_opcode", 64'(out_opcode), 64'd3);
      in_valid = 1'b0;
      tick();
      check("bp_drain", 64'(out_valid), 64'd0);

      // Opcode mask boundaries
      in_valid = 1'b1;
      in_instr = mk(5'h1E, 5'd0, 5'd0, 5'd0, 12'h000);
      tick();
      check("op1e_illegal", 64'(out_illegal), 64'd1);
      check("op1e_signed", 64'(out_imm_signed), 64'd0);
      in_instr = mk(5'h00, 5'd0, 5'd0, 5'd0, 12'h800);
      tick();
      check("op00_signed", 64'(out_imm_signed), 64'd0);
      check("op00_imm", 64'(out_imm), 64'h800);
      check("op00_illegal", 64'(out_illegal), 64'd0);
      in_instr = mk(5'h1C, 5'd0, 5'd0, 5'd0, 12'h000);
      tick();
      check("op1c_illegal", 64'(out_illegal), 64'd0);
      in_instr = mk(5'h1D, 5'd0, 5'd0, 5'd0, 12'h000);
      tick();
      check("op1d_illegal", 64'(out_illegal), 64'd1);
      in_instr = mk(5'h13, 5'd0, 5'd0, 5'd0, 12'h800);
      tick();
      check("op13_signed", 64'(out_imm_signed), 64'd1);
      in_instr = mk(5'h12, 5'd0, 5'd0, 5'd0, 12'h800);
      tick();
      check("op12_signed", 64'(out_imm_signed), 64'd0);
      in_valid = 1'b0;
      tick();
      check("op_drain", 64'(out_valid), 64'd0);

      // Flush while TWO with a word offered and out_ready high
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = mk(5'd4, 5'd0, 5'd0, 5'd0, 12'h0F0);
      in_pc     = 64'h3000;
      tick();
      in_pc = 64'h3004;
      tick();
      check("fl_two", 64'(in_ready), 64'd0);
      flush     = 1'b1;
      out_ready = 1'b1;
      in_pc     = 64'h3008;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("fl_valid", 64'(out_valid), 64'd0);
      check("fl_ready", 64'(in_ready), 64'd1);
      tick();
      check("fl_no_ghost", 64'(out_valid), 64'd0);

      // Flush while ONE voids the accept offered in the same cycle
      in_valid  = 1'b1;
      out_ready = 1'b0;
      in_pc     = 64'h3100;
      tick();
      check("fl1_one", 64'(out_valid), 64'd1);
      flush = 1'b1;
      in_pc = 64'h3104;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("fl1_valid", 64'(out_valid), 64'd0);
      tick();
      check("fl1_no_ghost", 64'(out_valid), 64'd0);
      in_valid = 1'b1;
      in_pc    = 64'h3200;
      tick();
      in_valid = 1'b0;
      check("fl_after_pc", out_pc, 64'h3200);

      // Asynchronous reset between edges while ONE
      in_instr = mk(5'h1E, 5'd7, 5'd7, 5'd7, 12'h123);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid", 64'(out_valid), 64'd0);
      check("ar_ready", 64'(in_ready), 64'd1);
      check("ar_pc", out_pc, 64'd0);
      check("ar_opcode", 64'(out_opcode), 64'd0);
      check("ar_imm", 64'(out_imm), 64'd0);
      in_valid = 1'b1;
      tick();
      check("ar_no_accept", 64'(out_valid), 64'd0);
      check("ar_no_accept_pc", out_pc, 64'd0);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
